// File: rtl/s2_frame_receiver_pkg.sv
// Shared widths, frame geometry and FSM state encoding for the S2 frame receiver.
package s2_frame_receiver_pkg;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 18;
    localparam int unsigned FRAME_LEN  = ADDR_W + DATA_W;
    localparam int unsigned NUM_FRAMES = 8;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned FCNT_W     = $clog2(NUM_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/s2_shift_in.sv
// MSB-first serial-to-parallel shifter with bit counter; full flags that the next bit completes the frame.
module s2_shift_in
    import s2_frame_receiver_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 sd,
    output logic                 full,
    output logic [FRAME_LEN-1:0] word
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (en) begin
            word <= {word[FRAME_LEN-2:0], sd};
            cnt  <= cnt + CNT_W'(1);
            // Registered look-ahead: set once FRAME_LEN-1 bits are held.
            full <= (cnt == CNT_W'(FRAME_LEN - 2));
        end
    end

endmodule

// File: rtl/s2_frame_receiver.sv
// Deserializes 21-bit sen/sd frames into RB2 word writes; flags short frames and completion of NUM_FRAMES commits.
module s2_frame_receiver
    import s2_frame_receiver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              S2_done,
    output logic              frame_err
);

    state_t              state;
    logic [FCNT_W-1:0]   frame_cnt;
    logic                shift_en;
    logic                shift_clr;
    logic                full;
    logic [FRAME_LEN-1:0] word;
    logic                unused_sig;

    assign unused_sig = ^{RB2_Q, word[FRAME_LEN-1]};

    s2_shift_in u_shift_in (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en),
        .clr  (shift_clr),
        .sd   (sd),
        .full (full),
        .word (word)
    );

    // Shifter control: capture while sen is low, clear on commit or abort.
    always_comb begin
        shift_en  = 1'b0;
        shift_clr = 1'b0;
        case (state)
            IDLE:    shift_en = ~sen;
            SHIFT: begin
                if (sen || full) shift_clr = 1'b1;
                else             shift_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            RB2_RW    <= 1'b1;
            RB2_A     <= '0;
            RB2_D     <= '0;
            S2_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            RB2_RW    <= 1'b1;
            frame_err <= 1'b0;
            if (!RB2_RW && frame_cnt == FCNT_W'(NUM_FRAMES)) S2_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (!sen) state <= SHIFT;
                end
                SHIFT: begin
                    if (sen) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (full) begin
                        // Commit on the edge sampling the last bit, using the live sd.
                        RB2_RW <= 1'b0;
                        RB2_A  <= word[FRAME_LEN-2 -: ADDR_W];
                        RB2_D  <= {word[DATA_W-2:0], sd};
                        if (frame_cnt != FCNT_W'(NUM_FRAMES))
                            frame_cnt <= frame_cnt + FCNT_W'(1);
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sen) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s2_frame_receiver.sv
// Directed self-checking bench for s2_frame_receiver: write capture, done timing, short/long frames, mid-frame reset.
module tb_s2_frame_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        sen;
    logic        sd;
    logic        RB2_RW;
    logic [2:0]  RB2_A;
    logic [17:0] RB2_D;
    logic [17:0] RB2_Q;
    logic        S2_done;
    logic        frame_err;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int err_n = 0;
    int done_cyc = -1;
    logic [2:0]  wr_a[$];
    logic [17:0] wr_d[$];
    int          wr_cyc[$];

    always #5 clk = ~clk;

    s2_frame_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .sen       (sen),
        .sd        (sd),
        .RB2_RW    (RB2_RW),
        .RB2_A     (RB2_A),
        .RB2_D     (RB2_D),
        .RB2_Q     (RB2_Q),
        .S2_done   (S2_done),
        .frame_err (frame_err)
    );

    always @(posedge clk) cyc++;

    // Output monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (RB2_RW === 1'b0) begin
                wr_a.push_back(RB2_A);
                wr_d.push_back(RB2_D);
                wr_cyc.push_back(cyc);
            end
            if (frame_err === 1'b1) err_n++;
            if (S2_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
        wr_cyc.delete();
        err_n    = 0;
        done_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sen = 1'b1;
            sd  = 1'b0;
        end
    endtask

    // Drive n bits MSB first with sen low, then one high cycle.
    task automatic send_raw(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sen = 1'b0;
            sd  = bits[n-1-i];
        end
        @(negedge clk);
        sen = 1'b1;
        sd  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sen = 1'b1;
        sd  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0]  byte_tab [18];
    logic [17:0] exp_d [8];
    logic [7:0]  bt;
    logic [31:0] fr;

    initial begin
        rst   = 1'b1;
        sen   = 1'b1;
        sd    = 1'b0;
        RB2_Q = '0;
        repeat (3) @(negedge clk);
        check("rst_rw",   32'(RB2_RW), 32'd1);
        check("rst_a",    32'(RB2_A), 32'd0);
        check("rst_d",    32'(RB2_D), 32'd0);
        check("rst_done", 32'(S2_done), 32'd0);
        check("rst_err",  32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(2);
        check("post_rst_rw", 32'(RB2_RW), 32'd1);

        // Single frame.
        clear_log();
        send_raw({11'd0, 3'b101, 18'h2A5C3}, 21);
        idle(3);
        check("single_cnt",  32'(wr_a.size()), 32'd1);
        if (wr_a.size() >= 1) begin
            check("single_a", 32'(wr_a[0]), 32'd5);
            check("single_d", 32'(wr_d[0]), 32'h2A5C3);
        end
        check("single_done", 32'(S2_done), 32'd0);
        check("single_err",  32'(err_n), 32'd0);

        // Eight bit-column frames, 1-cycle gaps.
        do_reset();
        clear_log();
        for (int j = 0; j < 18; j++) byte_tab[j] = 8'(j * 29 + 7);
        for (int k = 0; k < 8; k++) begin
            exp_d[k] = '0;
            for (int j = 0; j < 18; j++) begin
                bt = byte_tab[j];
                exp_d[k][j] = bt[7-k];
            end
        end
        for (int k = 0; k < 8; k++) send_raw({11'd0, 3'(k), exp_d[k]}, 21);
        idle(3);
        check("seq_cnt", 32'(wr_a.size()), 32'd8);
        if (wr_a.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("seq_a%0d", k), 32'(wr_a[k]), 32'(k));
                check($sformatf("seq_d%0d", k), 32'(wr_d[k]), 32'(exp_d[k]));
            end
            check("seq_done_cyc", 32'(done_cyc), 32'(wr_cyc[7] + 1));
        end
        check("seq_done", 32'(S2_done), 32'd1);

        // Short frame then a good frame to addr 2 (after done: still written).
        clear_log();
        send_raw(32'h00000ABC, 12);
        idle(2);
        check("short_wr",  32'(wr_a.size()), 32'd0);
        check("short_err", 32'(err_n), 32'd1);
        send_raw({11'd0, 3'd2, 18'h1B4E7}, 21);
        idle(3);
        check("after_short_cnt", 32'(wr_a.size()), 32'd1);
        if (wr_a.size() >= 1) begin
            check("after_short_a", 32'(wr_a[0]), 32'd2);
            check("after_short_d", 32'(wr_d[0]), 32'h1B4E7);
        end
        check("after_short_done", 32'(S2_done), 32'd1);
        check("after_short_err",  32'(err_n), 32'd1);

        // Long frame: 25 bits, trailing 4 ignored.
        clear_log();
        fr = {7'd0, 3'd3, 18'h0F0F5, 4'b1011};
        send_raw(fr, 25);
        idle(3);
        check("long_cnt", 32'(wr_a.size()), 32'd1);
        if (wr_a.size() >= 1) begin
            check("long_a", 32'(wr_a[0]), 32'd3);
            check("long_d", 32'(wr_d[0]), 32'h0F0F5);
        end
        check("long_err", 32'(err_n), 32'd0);

        // Reset after 10 bits, then a full frame to addr 6.
        clear_log();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sen = 1'b0;
            sd  = i[0];
        end
        @(negedge clk);
        rst = 1'b1;
        sen = 1'b1;
        sd  = 1'b0;
        @(negedge clk);
        check("mid_rst_done", 32'(S2_done), 32'd0);
        check("mid_rst_rw",   32'(RB2_RW), 32'd1);
        rst = 1'b0;
        idle(1);
        send_raw({11'd0, 3'd6, 18'h3FFFF}, 21);
        idle(3);
        check("mid_cnt", 32'(wr_a.size()), 32'd1);
        if (wr_a.size() >= 1) begin
            check("mid_a", 32'(wr_a[0]), 32'd6);
            check("mid_d", 32'(wr_d[0]), 32'h3FFFF);
        end
        check("mid_frame_cnt", 32'(dut.frame_cnt), 32'd1);
        check("mid_done",      32'(S2_done), 32'd0);
        check("mid_err",       32'(err_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/s2_frame_receiver.md
# s2_frame_receiver

Receiving end of the bit-serial frame link driven by the S1 transmitter. It samples `sen`/`sd`, deserializes each 21-bit frame into a 3-bit word address and an 18-bit data word, and writes that word into the RB2 register bank. After eight frames have been committed it raises `S2_done`. It sits between the serial link and RB2, in the same clock domain as the transmitter.

## Interface
- ADDR_W, 3, frame address field width, and RB2 address width
- DATA_W, 18, frame data field width, and RB2 word width
- NUM_FRAMES, 8, number of committed frames before `S2_done` asserts
- clk  in  1  single clock; link and RB2 are sampled/driven on posedge
- rst  in  1  asynchronous, active-high reset
- sen  in  1  frame enable, active low; high = idle/gap
- sd  in  1  serial data, MSB first
- RB2_RW  out  1  RB2 control: 1 = read/idle, 0 = write
- RB2_A  out  ADDR_W  RB2 write address
- RB2_D  out  DATA_W  RB2 write data
- RB2_Q  in  DATA_W  RB2 read port (unused, reserved)
- S2_done  out  1  all NUM_FRAMES frames written; sticky
- frame_err  out  1  one-cycle pulse: frame aborted short

## Operation
- Reset values: RB2_RW=1, RB2_A=0, RB2_D=0, S2_done=0, frame_err=0, bit count=0, frame count=0, shift register=0.
- Frame format, in sample order: addr[2], addr[1], addr[0], then data[17] down to data[0]. Total ADDR_W+DATA_W = 21 bits.
- States:
  - IDLE: wait for `sen`=0.
  - SHIFT: on each posedge with `sen`=0, shift `sd` in and increment the bit count.
  - COMMIT: entered at the edge that captures the 21st bit.
  - DRAIN: entered after COMMIT.
- IDLE→SHIFT: the first bit is captured on the same edge on which `sen`=0 is first seen.
- COMMIT:
  - At the edge that captures the 21st bit, register RB2_A=addr field, RB2_D={shift[16:0],sd} and RB2_RW=0.
  - On the next edge, RB2_RW returns to 1. RB2_A and RB2_D hold their values until the next commit.
  - Frame count increments.
- DRAIN: any extra `sd` bits while `sen` stays low are ignored, with no second write. Return to IDLE when `sen`=1.
- Short frame: `sen` rises in SHIFT with a bit count of 1..20.
  - Discard the frame; no write.
  - Pulse frame_err for one cycle.
  - Clear the bit count and return to IDLE.
- S2_done is set on the edge where RB2_RW returns to 1 after the NUM_FRAMES-th commit. Only reset clears it.
- Frames arriving after done are still written. S2_done stays 1 and the frame count saturates.
- Addresses are taken from the frame, not from the frame count. Duplicate addresses overwrite; the bank simply keeps the last write.
- Reset mid-frame: all state clears immediately and the partial frame is lost. The next `sen` falling edge starts a fresh frame.

## Timing
- The transmitter changes `sen`/`sd` on negedge, so they are stable at posedge. No synchronizer is used.
- Frame length is 21 cycles with `sen` low. The gap is at least 1 cycle with `sen` high.
- Back-to-back frames separated by a single high cycle must all be committed.
- Write latency: 0 cycles after the 21st sample edge, as registered outputs. The write pulse is exactly 1 cycle wide.
- S2_done asserts 1 cycle after the 8th write pulse begins.
- frame_err is registered and asserts on the edge where `sen`=1 is seen.

## Structure
- Shared package holds ADDR_W, DATA_W, FRAME_LEN (=ADDR_W+DATA_W), NUM_FRAMES, and the state enum {IDLE, SHIFT, DRAIN}. COMMIT is an action within the SHIFT→DRAIN transition, not a separate state.
- One sub-module, `s2_shift_in`:
  - Contains the FRAME_LEN shift register and the 5-bit bit counter.
  - Inputs: enable, clear, sd.
  - Outputs: full and the parallel word.
- The top level holds the FSM, RB2 output registers, frame counter, and the done/err flags.

## Test plan
- Reset check: hold rst high, then release → RB2_RW=1, RB2_A=0, RB2_D=0, S2_done=0, frame_err=0.
- Single frame: addr 3'b101, data 18'h2A5C3 → one cycle with RB2_RW=0, RB2_A=5, RB2_D=18'h2A5C3; S2_done stays 0.
- Full sequence: 8 frames carrying bit-column (7−k) of bytes 17..0 for k=0..7, with 1-cycle gaps.
  - Expect 8 write pulses at addresses 0..7 with the expected words.
  - Expect S2_done=1 one cycle after the 8th pulse.
- Short frame: raise `sen` after 12 bits → no write, frame_err pulses once; the following full frame for addr 2 writes correctly.
- Long frame: hold `sen` low for 25 bits → exactly one write, with data taken from bits 4..21 of the frame (bits 22..25 ignored).
- Reset mid-frame: assert rst after 10 bits, then send a full frame for addr 6, data 18'h3FFFF → single write to A=6, D=18'h3FFFF; frame count = 1.
